// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - memory-side bus responder backed by an on-chip word array
module bus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int MEM_WORDS      = 4096,
    parameter int LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LAT_W  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WDATA,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [IDX_W-1:0]         base_idx;
    logic [BUS_TAG_WIDTH-1:0] tag_q;
    logic [BEAT_W-1:0]        beat;
    logic [LAT_W-1:0]         lat;

    logic [IDX_W-1:0] req_base;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] next_idx;
    logic             last_beat;
    logic             accept;
    logic             mem_we;
    logic             load_first;
    logic             advance;

    // The address beat selects a line; bytes within the line and bits above the array are dropped.
    assign req_base  = bus_req[3 +: IDX_W] & ~IDX_W'(BEATS - 1);
    assign cur_idx   = base_idx + IDX_W'(beat);
    assign next_idx  = cur_idx + 1'b1;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mem_we     = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus_reqcyc) begin
                    accept     = 1'b1;
                    state_next = bus_reqtag[BUS_TAG_WIDTH-1] ? S_WDATA : S_WAIT;
                end
            end
            S_WDATA: begin
                if (bus_reqcyc) begin
                    mem_we = 1'b1;
                    if (last_beat) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (lat == '0) begin
                    load_first = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_respack) begin
                    advance = 1'b1;
                    if (last_beat) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Line/tag latches, counters and registered bus outputs; the next beat's word is read on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
            base_idx    <= '0;
            tag_q       <= '0;
            beat        <= '0;
            lat         <= '0;
        end else begin
            bus_reqack  <= accept | mem_we;
            bus_respcyc <= (state_next == S_RESP);
            if (accept) begin
                base_idx <= req_base;
                tag_q    <= bus_reqtag;
                beat     <= '0;
                lat      <= LAT_W'(LATENCY);
            end
            if (mem_we) begin
                beat <= beat + 1'b1;
            end
            if (state == S_WAIT && lat != '0) begin
                lat <= lat - 1'b1;
            end
            if (load_first) begin
                bus_resp    <= mem[base_idx];
                bus_resptag <= tag_q;
                beat        <= '0;
            end
            if (advance) begin
                bus_resp <= mem[next_idx];
                beat     <= beat + 1'b1;
            end
        end
    end

    // Backing array write port; contents survive reset, so a reset cycle only blocks the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[cur_idx] <= bus_req;
        end
    end

endmodule
